// File: rtl/flood_mask_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// flood_mask_filter
// ----------------------------------------------------------------------------
// Prunes the IOQ destination-port field of each packet with a programmable
// port-enable mask and drops packets whose pruned mask is zero. Counts passed
// and dropped packets; mask and counters sit on the UDP register chain.
//
// Ports:
//   clk, reset_L            clock, asynchronous active-low reset
//   in_data/in_ctrl/in_wr   upstream word, control, write strobe
//   in_rdy                  high when the input FIFO can take a word
//   out_data/out_ctrl/out_wr registered downstream word and strobe
//   out_rdy                 downstream ready
//   reg_*_in / reg_*_out    register chain (registered, 1-cycle latency)
//
// Revision: 1.0 - initial release
// ============================================================================

// Fallbacks for the project-wide defines; the shared defines file wins.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 8'hff
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 48
`endif

module flood_mask_filter #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH/8,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int TAG               = 0
) (
  input  logic                            clk,
  input  logic                            reset_L,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic [CTRL_WIDTH-1:0]           in_ctrl,
  input  logic                            in_wr,
  output logic                            in_rdy,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [CTRL_WIDTH-1:0]           out_ctrl,
  output logic                            out_wr,
  input  logic                            out_rdy,
  input  logic                            reg_req_in,
  input  logic                            reg_ack_in,
  input  logic                            reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,
  output logic                            reg_req_out,
  output logic                            reg_ack_out,
  output logic                            reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out
);

  localparam int AW     = `UDP_REG_ADDR_WIDTH;
  localparam int RW     = `CPCI_NF2_DATA_WIDTH;
  localparam int DST_LO = `IOQ_DST_PORT_POS;
  localparam int WW     = CTRL_WIDTH + DATA_WIDTH;
  localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(`IO_QUEUE_STAGE_NUM);
  localparam logic [AW-3:0]         TAG_BITS = (AW-2)'(TAG);

  // ---------------- 4-deep fallthrough input FIFO ----------------
  logic [WW-1:0]         fifo_mem [0:3];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_count;
  logic                  empty, full, fifo_wr, pop;
  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;

  assign empty   = (fifo_count == 3'd0);
  assign full    = (fifo_count == 3'd4);
  // One slot of slack: upstream may already have a word in flight.
  assign in_rdy  = (fifo_count < 3'd3);
  assign fifo_wr = in_wr && !full;
  assign {head_ctrl, head_data} = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b00, fifo_wr} - {2'b00, pop};
    end
  end

  // ---------------- packet state machine ----------------
  typedef enum logic [2:0] {
    S_SOP       = 3'd0,
    S_HDR       = 3'd1,
    S_DATA      = 3'd2,
    S_DROP_HDR  = 3'd3,
    S_DROP_DATA = 3'd4
  } state_t;

  state_t                state;
  logic [15:0]           port_mask;
  logic [31:0]           pkts_passed, pkts_dropped;
  logic [15:0]           masked_dst;
  logic                  is_ioq, sop_drop, passing;
  logic [DATA_WIDTH-1:0] fwd_data;

  always_comb begin
    masked_dst = head_data[DST_LO +: 16] & port_mask;
    is_ioq     = (head_ctrl == IOQ_CTRL);
    sop_drop   = is_ioq && (masked_dst == 16'd0);
    passing    = ((state == S_SOP) && !sop_drop) || (state == S_HDR) || (state == S_DATA);
    // Discarded words never reach the output, so they ignore backpressure.
    pop        = !empty && (passing ? out_rdy : 1'b1);
    fwd_data   = head_data;
    if ((state == S_SOP) && is_ioq) fwd_data[DST_LO +: 16] = masked_dst;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= S_SOP;
      out_wr       <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
      pkts_passed  <= 32'd0;
      pkts_dropped <= 32'd0;
    end else begin
      out_wr <= pop && passing;
      if (pop && passing) begin
        out_data <= fwd_data;
        out_ctrl <= head_ctrl;
      end
      if (pop) begin
        case (state)
          S_SOP: begin
            if (sop_drop) begin
              pkts_dropped <= pkts_dropped + 32'd1;
              state        <= S_DROP_HDR;
            end else begin
              pkts_passed  <= pkts_passed + 32'd1;
              state        <= S_HDR;
            end
          end
          S_HDR:       if (head_ctrl == '0) state <= S_DATA;
          S_DATA:      if (head_ctrl != '0) state <= S_SOP;
          S_DROP_HDR:  if (head_ctrl == '0) state <= S_DROP_DATA;
          S_DROP_DATA: if (head_ctrl != '0) state <= S_SOP;
          default:     state <= S_SOP;
        endcase
      end
    end
  end

  // ---------------- register chain ----------------
  logic          tag_hit;
  logic [RW-1:0] rd_val;

  assign tag_hit = reg_req_in && !reg_ack_in && (reg_addr_in[AW-1:2] == TAG_BITS);

  always_comb begin
    rd_val = '0;
    case (reg_addr_in[1:0])
      2'd0:    rd_val = {{(RW-16){1'b0}}, port_mask};
      2'd1:    rd_val = RW'(pkts_passed);
      2'd2:    rd_val = RW'(pkts_dropped);
      default: rd_val = '0;
    endcase
  end

  // The mask is only sampled at an SOP decision, so a write here can never
  // alter a packet that is already in flight.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      reg_req_out     <= 1'b0;
      reg_ack_out     <= 1'b0;
      reg_rd_wr_L_out <= 1'b0;
      reg_addr_out    <= '0;
      reg_data_out    <= '0;
      reg_src_out     <= '0;
      port_mask       <= 16'hFFFF;
    end else begin
      reg_req_out     <= reg_req_in;
      reg_rd_wr_L_out <= reg_rd_wr_L_in;
      reg_addr_out    <= reg_addr_in;
      reg_src_out     <= reg_src_in;
      if (tag_hit) begin
        reg_ack_out  <= 1'b1;
        reg_data_out <= reg_rd_wr_L_in ? rd_val : reg_data_in;
        if (!reg_rd_wr_L_in && (reg_addr_in[1:0] == 2'd0))
          port_mask <= reg_data_in[15:0];
      end else begin
        reg_ack_out  <= reg_ack_in;
        reg_data_out <= reg_data_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flood_mask_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_flood_mask_filter
// ----------------------------------------------------------------------------
// Self-checking bench: table-driven mask vectors, hand-written corner
// sequences and randomized packet traffic against a packet-level model.
// Revision: 1.0 - initial release
// ============================================================================

module tb_flood_mask_filter;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int SW = 2;
  localparam int AW = 23;
  localparam int RW = 32;

  typedef logic [CW+DW-1:0] word_t;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] dst;
    bit          pass;
    logic [15:0] exp_dst;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_wr;
  logic          in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [RW-1:0] reg_data_in;
  logic [SW-1:0] reg_src_in;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [RW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;

  always #5 clk = ~clk;

  flood_mask_filter #(
    .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .UDP_REG_SRC_WIDTH(SW), .TAG(0)
  ) dut (
    .clk(clk), .reset_L(reset_L),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out)
  );

  word_t       in_q[$];
  word_t       exp_q[$];
  word_t       got_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rdy_mode = 1;      // 0: out_rdy low, 1: high, 2: random
  int          exp_passed = 0;
  int          exp_dropped = 0;
  logic [15:0] model_mask = 16'hFFFF;
  vec_t        tbl[8];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock: record output, then drive the next input word and out_rdy.
  task automatic cycle();
    logic rdy_before;
    rdy_before = out_rdy;
    @(posedge clk); #1;
    if (out_wr) begin
      got_q.push_back({out_ctrl, out_data});
      check("out_wr_needs_prior_rdy", {71'd0, rdy_before}, 72'd1);
    end
    in_wr = 1'b0;
    if (in_q.size() > 0 && in_rdy) begin
      {in_ctrl, in_data} = in_q.pop_front();
      in_wr = 1'b1;
    end
    case (rdy_mode)
      0:       out_rdy = 1'b0;
      1:       out_rdy = 1'b1;
      default: out_rdy = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Packet-level model: the whole packet either vanishes or is copied with
  // its destination field ANDed with the current mask.
  function automatic void model_packet(input word_t pkt[$]);
    word_t       h;
    logic [15:0] m;
    h = pkt[0];
    if (h[71:64] == 8'hFF) begin
      m = h[63:48] & model_mask;
      if (m == 16'd0) begin
        exp_dropped++;
        return;
      end
      h[63:48] = m;
    end
    exp_passed++;
    exp_q.push_back(h);
    for (int i = 1; i < pkt.size(); i++) exp_q.push_back(pkt[i]);
  endfunction

  task automatic make_pkt(input logic [7:0] sop_ctrl, input logic [15:0] dst, input int nhdr,
                          input int ndata, input logic [7:0] eop_ctrl, output word_t pkt[$]);
    pkt = {};
    pkt.push_back({sop_ctrl, dst, 16'($urandom), 32'($urandom)});
    for (int i = 0; i < nhdr; i++) pkt.push_back({8'h10, 32'($urandom), 32'($urandom)});
    for (int i = 0; i < ndata; i++) pkt.push_back({8'h00, 32'($urandom), 32'($urandom)});
    pkt.push_back({eop_ctrl, 32'($urandom), 32'($urandom)});
  endtask

  task automatic send(input word_t pkt[$]);
    model_packet(pkt);
    foreach (pkt[i]) in_q.push_back(pkt[i]);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (in_q.size() > 0 && n < 3000) begin
      cycle();
      n++;
    end
    check({name, "_drain_timeout"}, 72'(n >= 3000), 72'd0);
    repeat (40) cycle();
  endtask

  task automatic compare(input string name);
    int n;
    check({name, "_word_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_word"}, got_q[i], exp_q[i]);
    got_q = {};
    exp_q = {};
  endtask

  task automatic reg_op(input logic [1:0] off, input logic wr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
    reg_req_in     = 1'b1;
    reg_ack_in     = 1'b0;
    reg_rd_wr_L_in = !wr;
    reg_addr_in    = {21'd0, off};
    reg_data_in    = wdata;
    reg_src_in     = 2'b01;
    cycle();
    check("reg_ack", {71'd0, reg_ack_out}, 72'd1);
    rdata = reg_data_out;
    reg_req_in = 1'b0;
    reg_rd_wr_L_in = 1'b1;
  endtask

  task automatic reg_write(input logic [1:0] off, input logic [31:0] v);
    logic [31:0] d;
    reg_op(off, 1'b1, v, d);
  endtask

  task automatic reg_read(input string name, input logic [1:0] off, input logic [31:0] expv);
    logic [31:0] d;
    reg_op(off, 1'b0, 32'hDEADBEEF, d);
    check(name, 72'(d), 72'(expv));
  endtask

  initial begin
    word_t pkt[$];
    word_t pkt_b[$];
    int    n;

    tbl[0] = '{16'hFFFF, 16'h0055, 1'b1, 16'h0055};
    tbl[1] = '{16'h000F, 16'h00F5, 1'b1, 16'h0005};
    tbl[2] = '{16'h000F, 16'h0050, 1'b0, 16'h0000};
    tbl[3] = '{16'h0001, 16'h0001, 1'b1, 16'h0001};
    tbl[4] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000};
    tbl[5] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000};
    tbl[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'h0000};
    tbl[7] = '{16'hA5A5, 16'hFFFF, 1'b1, 16'hA5A5};

    reset_L = 1'b0; in_wr = 1'b0; in_data = '0; in_ctrl = '0; out_rdy = 1'b1;
    reg_req_in = 1'b0; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = '0; reg_data_in = '0; reg_src_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wr", 72'(out_wr), 72'd0);
    check("rst_out_data", 72'(out_data), 72'd0);
    check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    check("rst_reg_ack_out", 72'(reg_ack_out), 72'd0);
    check("rst_reg_data_out", 72'(reg_data_out), 72'd0);
    check("rst_in_rdy", 72'(in_rdy), 72'd1);
    reset_L = 1'b1;
    cycle();
    reg_read("rst_port_mask", 2'd0, 32'h0000FFFF);
    reg_read("rst_passed", 2'd1, 32'd0);
    reg_read("rst_dropped", 2'd2, 32'd0);

    // Default mask: packet passes unchanged, 5 words.
    make_pkt(8'hFF, 16'h0055, 0, 3, 8'h40, pkt);
    send(pkt);
    drain("default");
    check("default_out_words", 72'(got_q.size()), 72'd5);
    compare("default");
    reg_read("default_passed", 2'd1, 32'd1);

    // Table of mask / destination vectors.
    for (int t = 0; t < 8; t++) begin
      reg_write(2'd0, {16'h0, tbl[t].mask});
      model_mask = tbl[t].mask;
      make_pkt(8'hFF, tbl[t].dst, 0, 3, 8'h40, pkt);
      send(pkt);
      drain("tbl");
      check("tbl_out_words", 72'(got_q.size()), tbl[t].pass ? 72'd5 : 72'd0);
      if (tbl[t].pass && got_q.size() > 0) begin
        check("tbl_dst", 72'(got_q[0][63:48]), 72'(tbl[t].exp_dst));
        check("tbl_hdr_rest", 72'({got_q[0][71:64], got_q[0][47:0]}),
              72'({pkt[0][71:64], pkt[0][47:0]}));
      end
      compare("tbl");
    end

    // Dropped packet drains with out_rdy held low.
    reg_write(2'd0, 32'h0000000F);
    model_mask = 16'h000F;
    rdy_mode = 0;
    cycle();
    make_pkt(8'hFF, 16'h0050, 1, 8, 8'h01, pkt);
    send(pkt);
    drain("drop_rdy_low");
    check("drop_rdy_low_in_rdy", 72'(in_rdy), 72'd1);
    check("drop_rdy_low_no_out", 72'(got_q.size()), 72'd0);
    compare("drop_rdy_low");
    rdy_mode = 1;
    reg_read("drop_dropped", 2'd2, 32'(exp_dropped));

    // Back-to-back pass/drop/pass with random backpressure.
    rdy_mode = 2;
    make_pkt(8'hFF, 16'h0003, 0, 3, 8'h02, pkt); send(pkt);
    make_pkt(8'hFF, 16'h0030, 0, 3, 8'h02, pkt); send(pkt);
    make_pkt(8'hFF, 16'h0007, 0, 3, 8'h02, pkt); send(pkt);
    drain("b2b");
    check("b2b_out_words", 72'(got_q.size()), 72'd10);
    compare("b2b");
    rdy_mode = 1;

    // Mask written while a packet is in flight.
    reg_write(2'd0, 32'h0000FFFF);
    model_mask = 16'hFFFF;
    make_pkt(8'hFF, 16'h0006, 0, 8, 8'h04, pkt);
    send(pkt);
    n = 0;
    while (got_q.size() == 0 && n < 100) begin
      cycle();
      n++;
    end
    check("midpkt_first_out_timeout", 72'(n >= 100), 72'd0);
    reg_write(2'd0, 32'h00000001);
    model_mask = 16'h0001;
    make_pkt(8'hFF, 16'h0006, 0, 2, 8'h04, pkt_b); send(pkt_b);
    make_pkt(8'hFF, 16'h0003, 0, 2, 8'h04, pkt_b); send(pkt_b);
    drain("midpkt");
    check("midpkt_out_words", 72'(got_q.size()), 72'(10 + 4));
    compare("midpkt");

    // Randomized traffic in groups sharing one mask each.
    for (int g = 0; g < 6; g++) begin
      logic [15:0] m;
      m = (g == 0) ? 16'hFFFF : (16'($urandom) & 16'($urandom));
      reg_write(2'd0, {16'($urandom), m});
      model_mask = m;
      rdy_mode = 2;
      for (int p = 0; p < 8; p++) begin
        make_pkt(($urandom_range(0, 5) == 0) ? 8'h20 : 8'hFF, 16'($urandom),
                 $urandom_range(0, 2), $urandom_range(1, 6),
                 8'h01 << $urandom_range(0, 7), pkt);
        send(pkt);
      end
      drain("rand");
      compare("rand");
      rdy_mode = 1;
    end

    // Register map.
    reg_read("reg_passed", 2'd1, 32'(exp_passed));
    reg_read("reg_dropped", 2'd2, 32'(exp_dropped));
    reg_read("reg_off3", 2'd3, 32'd0);
    reg_write(2'd0, 32'h1234ABCD);
    model_mask = 16'hABCD;
    reg_read("reg_mask_upper_zero", 2'd0, 32'h0000ABCD);
    reg_write(2'd3, 32'h00000000);
    reg_write(2'd1, 32'h00000000);
    reg_read("reg_mask_after_ro_writes", 2'd0, 32'h0000ABCD);
    reg_read("reg_passed_after_ro_write", 2'd1, 32'(exp_passed));

    // Non-matching tag: passes straight through.
    reg_req_in = 1'b1; reg_ack_in = 1'b0; reg_rd_wr_L_in = 1'b1;
    reg_addr_in = {21'd5, 2'd1}; reg_data_in = 32'hCAFEF00D; reg_src_in = 2'b10;
    cycle();
    check("tag_miss_ack", 72'(reg_ack_out), 72'd0);
    check("tag_miss_data", 72'(reg_data_out), 72'h0CAFEF00D);
    check("tag_miss_addr", 72'(reg_addr_out), 72'({21'd5, 2'd1}));
    check("tag_miss_req_src", 72'({reg_req_out, reg_src_out}), 72'({1'b1, 2'b10}));
    // Matching tag but already acked: also passes through.
    reg_ack_in = 1'b1; reg_addr_in = {21'd0, 2'd1};
    cycle();
    check("acked_pass_ack", 72'(reg_ack_out), 72'd1);
    check("acked_pass_data", 72'(reg_data_out), 72'h0CAFEF00D);
    reg_req_in = 1'b0; reg_ack_in = 1'b0;

    // Reset mid-packet.
    make_pkt(8'hFF, 16'hFFFF, 0, 8, 8'h40, pkt);
    foreach (pkt[i]) in_q.push_back(pkt[i]);
    repeat (4) cycle();
    reset_L = 1'b0;
    in_wr = 1'b0;
    #2;
    check("midrst_out_wr", 72'(out_wr), 72'd0);
    check("midrst_out_data", 72'(out_data), 72'd0);
    check("midrst_out_ctrl", 72'(out_ctrl), 72'd0);
    check("midrst_reg_outs", 72'({reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_src_out}), 72'd0);
    check("midrst_reg_addr_data", 72'({reg_addr_out, reg_data_out}), 72'd0);
    in_q = {}; got_q = {}; exp_q = {};
    exp_passed = 0; exp_dropped = 0; model_mask = 16'hFFFF;
    @(posedge clk); #1;
    reset_L = 1'b1;
    cycle();
    reg_read("midrst_passed", 2'd1, 32'd0);
    reg_read("midrst_dropped", 2'd2, 32'd0);
    reg_read("midrst_mask", 2'd0, 32'h0000FFFF);
    make_pkt(8'hFF, 16'h0101, 0, 2, 8'h80, pkt);
    send(pkt);
    drain("post_rst");
    compare("post_rst");
    reg_read("post_rst_passed", 2'd1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
